// File: rtl/phy_pkg.sv
// Shared constants and state encoding for the PHY transmit scheduler.
package phy_pkg;

    localparam int          DATA_W    = 32;
    localparam logic [31:0] IDLE_WORD = 32'h0000BCBC;
    localparam logic [7:0]  COMMA     = 8'hBC;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        TRAIN  = 2'b01,
        ACTIVE = 2'b10
    } link_state_t;

endpackage

// File: rtl/phy_rr_arbiter.sv
// Two-requester burst-limited arbiter: the owner keeps the bus until the
// other side is waiting and the owner has used BURST_MAX consecutive grants.
module phy_rr_arbiter
    import phy_pkg::*;
#(
    parameter int BURST_MAX = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic active,
    input  logic req0_valid,
    input  logic req1_valid,
    output logic req0_ready,
    output logic req1_ready,
    output logic transfer,
    output logic grant_sel
);

    localparam int BW = $clog2(BURST_MAX + 1);

    logic          owner_reg;
    logic [BW-1:0] burst_cnt_reg;
    logic          owner_valid;
    logic          other_valid;
    logic          burst_full;
    logic          grant_other;
    logic          grant_owner;

    assign owner_valid = owner_reg ? req1_valid : req0_valid;
    assign other_valid = owner_reg ? req0_valid : req1_valid;
    assign burst_full  = (burst_cnt_reg == BW'(BURST_MAX));
    assign grant_other = other_valid && (!owner_valid || burst_full);
    assign grant_owner = !grant_other && owner_valid;

    assign grant_sel  = grant_other ? ~owner_reg : owner_reg;
    assign transfer   = active && (grant_other || grant_owner);
    assign req0_ready = transfer && !grant_sel;
    assign req1_ready = transfer && grant_sel;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner_reg     <= 1'b0;
            burst_cnt_reg <= '0;
        end else if (transfer) begin
            if (grant_other) begin
                owner_reg     <= ~owner_reg;
                burst_cnt_reg <= BW'(1);
            end else if (!burst_full) begin
                burst_cnt_reg <= burst_cnt_reg + BW'(1);
            end
        end
    end

endmodule

// File: rtl/phy_link_scheduler.sv
// Link bring-up FSM and registered PHY transmit stage; holds comma/idle until
// the receive side is aligned, then forwards arbitrated requester words.
module phy_link_scheduler
    import phy_pkg::*;
#(
    parameter int          DATA_W    = phy_pkg::DATA_W,
    parameter logic [31:0] IDLE_WORD = phy_pkg::IDLE_WORD,
    parameter logic [7:0]  COMMA     = phy_pkg::COMMA,
    parameter int          ALIGN_CNT = 4,
    parameter int          LOSS_CNT  = 8,
    parameter int          BURST_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] req0_data,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req1_data,
    input  logic              req1_valid,
    output logic              req1_ready,
    output logic [DATA_W-1:0] phy_tx_data,
    output logic              phy_tx_valid,
    input  logic [DATA_W-1:0] phy_rx_data,
    input  logic              phy_rx_valid,
    output logic              link_up,
    output logic [1:0]        link_state
);

    localparam int AW = $clog2(ALIGN_CNT + 1);
    localparam int LW = $clog2(LOSS_CNT + 1);

    link_state_t       state_reg;
    logic [AW-1:0]     align_cnt_reg;
    logic [LW-1:0]     loss_cnt_reg;
    logic [DATA_W-1:0] tx_data_reg;
    logic              tx_valid_reg;
    logic              link_up_reg;
    logic              transfer;
    logic              grant_sel;
    logic              comma_cycle;
    logic              loss_cycle;
    logic              unused_rx_bits;

    assign comma_cycle    = !phy_rx_valid && (phy_rx_data[7:0] == COMMA);
    assign loss_cycle     = !phy_rx_valid && (phy_rx_data[7:0] != COMMA);
    assign unused_rx_bits = ^phy_rx_data[DATA_W-1:8];

    phy_rr_arbiter #(
        .BURST_MAX (BURST_MAX)
    ) u_arbiter (
        .clk        (clk),
        .reset      (reset),
        .active     (state_reg == ACTIVE),
        .req0_valid (req0_valid),
        .req1_valid (req1_valid),
        .req0_ready (req0_ready),
        .req1_ready (req1_ready),
        .transfer   (transfer),
        .grant_sel  (grant_sel)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= IDLE;
            align_cnt_reg <= '0;
            loss_cnt_reg  <= '0;
            tx_data_reg   <= IDLE_WORD;
            tx_valid_reg  <= 1'b0;
            link_up_reg   <= 1'b0;
        end else begin
            // The word accepted on a loss edge is still emitted: transfer is
            // evaluated against the state before this edge.
            tx_data_reg  <= transfer ? (grant_sel ? req1_data : req0_data) : IDLE_WORD;
            tx_valid_reg <= transfer;
            case (state_reg)
                IDLE: begin
                    state_reg   <= TRAIN;
                    link_up_reg <= 1'b0;
                end
                TRAIN: begin
                    if (!comma_cycle) begin
                        align_cnt_reg <= '0;
                    end else if (align_cnt_reg == AW'(ALIGN_CNT - 1)) begin
                        state_reg     <= ACTIVE;
                        link_up_reg   <= 1'b1;
                        align_cnt_reg <= '0;
                        loss_cnt_reg  <= '0;
                    end else begin
                        align_cnt_reg <= align_cnt_reg + AW'(1);
                    end
                end
                ACTIVE: begin
                    if (!loss_cycle) begin
                        loss_cnt_reg <= '0;
                    end else if (loss_cnt_reg == LW'(LOSS_CNT - 1)) begin
                        state_reg     <= TRAIN;
                        link_up_reg   <= 1'b0;
                        align_cnt_reg <= '0;
                        loss_cnt_reg  <= '0;
                    end else begin
                        loss_cnt_reg <= loss_cnt_reg + LW'(1);
                    end
                end
                default: begin
                    state_reg   <= IDLE;
                    link_up_reg <= 1'b0;
                end
            endcase
        end
    end

    assign phy_tx_data  = tx_data_reg;
    assign phy_tx_valid = tx_valid_reg;
    assign link_up      = link_up_reg;
    assign link_state   = state_reg;

endmodule

// File: tb/tb_phy_link_scheduler.sv
// Directed bench for phy_link_scheduler: training, streaming, contention,
// link loss and reset mid-burst, with hand-computed expectations.
module tb_phy_link_scheduler;
    import phy_pkg::*;

    localparam logic [31:0] WA = 32'hAAAA0001;
    localparam logic [31:0] WB = 32'hBBBB0002;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] req0_data, req1_data, phy_rx_data, phy_tx_data;
    logic        req0_valid, req1_valid, req0_ready, req1_ready;
    logic        phy_rx_valid, phy_tx_valid, link_up;
    logic [1:0]  link_state;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    phy_link_scheduler dut (
        .clk          (clk),
        .reset        (reset),
        .req0_data    (req0_data),
        .req0_valid   (req0_valid),
        .req0_ready   (req0_ready),
        .req1_data    (req1_data),
        .req1_valid   (req1_valid),
        .req1_ready   (req1_ready),
        .phy_tx_data  (phy_tx_data),
        .phy_tx_valid (phy_tx_valid),
        .phy_rx_data  (phy_rx_data),
        .phy_rx_valid (phy_rx_valid),
        .link_up      (link_up),
        .link_state   (link_state)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [31:0] rdy();
        return {30'd0, req1_ready, req0_ready};
    endfunction

    task automatic check_idle_out(input string tag);
        check_val({tag, "_txd"}, phy_tx_data, IDLE_WORD);
        check_val({tag, "_txv"}, 32'(phy_tx_valid), 32'd0);
    endtask

    task automatic set_comma();
        phy_rx_valid = 1'b0;
        phy_rx_data  = IDLE_WORD;
    endtask

    task automatic set_rx_ok();
        phy_rx_valid = 1'b1;
        phy_rx_data  = 32'd0;
    endtask

    initial begin
        logic [31:0] sw [3];
        logic [8:0]  seq_c;
        logic [5:0]  seq_r;
        logic [4:0]  seq_p;
        sw[0] = 32'hFFFFFFFF;
        sw[1] = 32'hF4FFEF7F;
        sw[2] = 32'hE8EEE4EE;
        seq_c = 9'b000011110;
        seq_r = 6'b110000;
        seq_p = 5'b10000;

        // Reset held for three cycles with both requesters asking.
        reset = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_data = WA; req1_data = WB;
        set_rx_ok();
        repeat (3) @(negedge clk);
        check_idle_out("rst");
        check_val("rst_link_up", 32'(link_up), 32'd0);
        check_val("rst_state", 32'(link_state), 32'(IDLE));
        check_val("rst_rdy", rdy(), 32'd0);
        reset = 1'b1;
        #1 check_val("rel_state", 32'(link_state), 32'(IDLE));
        tick();
        check_val("train_state", 32'(link_state), 32'(TRAIN));
        check_val("train_rdy", rdy(), 32'd0);
        check_idle_out("train");

        // Three commas, a glitch word, then four commas.
        set_comma();
        repeat (3) tick();
        check_val("c3_link_up", 32'(link_up), 32'd0);
        phy_rx_data = 32'd0;
        tick();
        check_val("glitch_link_up", 32'(link_up), 32'd0);
        check_val("glitch_state", 32'(link_state), 32'(TRAIN));
        set_comma();
        repeat (3) tick();
        check_val("c3b_link_up", 32'(link_up), 32'd0);
        check_val("c3b_rdy", rdy(), 32'd0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick();
        check_val("c4_link_up", 32'(link_up), 32'd1);
        check_val("c4_state", 32'(link_state), 32'(ACTIVE));
        set_rx_ok();

        // Lone requester streams back-to-back.
        for (int i = 0; i < 3; i++) begin
            req0_valid = 1'b1;
            req0_data  = sw[i];
            #1 check_val("single_rdy", rdy(), 32'd1);
            tick();
            check_val("single_txd", phy_tx_data, sw[i]);
            check_val("single_txv", 32'(phy_tx_valid), 32'd1);
        end
        req0_valid = 1'b0;
        tick();
        check_idle_out("single_end");

        // Contention from owner 0 with three grants already used.
        req0_data = WA; req0_valid = 1'b1;
        req1_valid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            #1 check_val("cont_rdy", rdy(), seq_c[i] ? 32'd2 : 32'd1);
            tick();
            check_val("cont_txd", phy_tx_data, seq_c[i] ? WB : WA);
        end
        req0_valid = 1'b0;

        // Link loss with requester 1 streaming through it.
        phy_rx_valid = 1'b0;
        phy_rx_data  = 32'h12345678;
        repeat (7) tick();
        check_val("loss7_link_up", 32'(link_up), 32'd1);
        #1 check_val("loss7_rdy", rdy(), 32'd2);
        tick();
        check_val("loss_link_up", 32'(link_up), 32'd0);
        check_val("loss_state", 32'(link_state), 32'(TRAIN));
        check_val("loss_last_txd", phy_tx_data, WB);
        check_val("loss_last_txv", 32'(phy_tx_valid), 32'd1);
        check_val("loss_rdy", rdy(), 32'd0);
        tick();
        check_idle_out("loss_after");
        set_comma();
        repeat (3) tick();
        check_val("relink3", 32'(link_up), 32'd0);
        req1_valid = 1'b0;
        tick();
        check_val("relink_link_up", 32'(link_up), 32'd1);
        check_val("relink_state", 32'(link_state), 32'(ACTIVE));
        set_rx_ok();

        // Owner 1 is saturated; both valid, then reset during the req1 block.
        req0_valid = 1'b1; req1_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1 check_val("burst_rdy", rdy(), seq_r[i] ? 32'd2 : 32'd1);
            tick();
            check_val("burst_txd", phy_tx_data, seq_r[i] ? WB : WA);
        end
        #2 reset = 1'b0;
        #1 check_idle_out("midrst");
        check_val("midrst_link_up", 32'(link_up), 32'd0);
        check_val("midrst_state", 32'(link_state), 32'(IDLE));
        check_val("midrst_rdy", rdy(), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        tick();
        set_comma();
        repeat (4) tick();
        check_val("post_link_up", 32'(link_up), 32'd1);
        set_rx_ok();
        for (int i = 0; i < 5; i++) begin
            #1 check_val("post_rdy", rdy(), seq_p[i] ? 32'd2 : 32'd1);
            tick();
            check_val("post_txd", phy_tx_data, seq_p[i] ? WB : WA);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench timeout");
    end

endmodule

// File: doc/phy_link_scheduler.md
Name: phy_link_scheduler

Overview:
- Sequences the PHY transmit datapath: holds the link in comma/idle training until the receive side reports alignment, then shares the 32-bit PHY input bus between two requesters.
- When no requester transfers, it inserts the idle word 0x0000BCBC with valid low.
- Sits directly in front of the PHY transmit input and observes the PHY receive output.

Parameters:
- DATA_W, 32, width of every data bus.
- IDLE_WORD, 32'h0000BCBC, word driven when no data is sent.
- COMMA, 8'hBC, comma byte checked in rx_data[7:0].
- ALIGN_CNT, 4, consecutive received commas required to declare link up.
- LOSS_CNT, 8, consecutive received non-comma invalid words that declare link loss.
- BURST_MAX, 4, maximum consecutive grants to one requester while the other is waiting.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low; asserted when 0.
- req0_data  in  DATA_W  requester 0 data.
- req0_valid  in  1  requester 0 has a word.
- req0_ready  out  1  requester 0 word accepted this cycle.
- req1_data  in  DATA_W  requester 1 data.
- req1_valid  in  1  requester 1 has a word.
- req1_ready  out  1  requester 1 word accepted this cycle.
- phy_tx_data  out  DATA_W  to PHY input_bus.
- phy_tx_valid  out  1  to PHY valid.
- phy_rx_data  in  DATA_W  from PHY output_bus.
- phy_rx_valid  in  1  PHY receive word valid.
- link_up  out  1  registered; high in ACTIVE.
- link_state  out  2  current FSM state.

Behaviour:
- Reset (reset==0, asynchronous) drives: phy_tx_data=IDLE_WORD, phy_tx_valid=0, link_up=0, link_state=IDLE, owner=0, burst_cnt=0, align_cnt=0, loss_cnt=0. Both ready outputs are 0 while in reset.
- FSM encoding: IDLE=2'b00, TRAIN=2'b01, ACTIVE=2'b10; 2'b11 is illegal and returns to IDLE.
- IDLE: entered from reset. Moves to TRAIN on the first clock edge after reset deasserts.
- TRAIN transmit side: phy_tx_data=IDLE_WORD, phy_tx_valid=0, both readys held 0.
- TRAIN comma detection: a "comma cycle" is phy_rx_valid==0 with phy_rx_data[7:0]==COMMA.
  - Each comma cycle increments align_cnt.
  - Any other cycle clears align_cnt to 0.
- TRAIN exit: when align_cnt would reach ALIGN_CNT, the FSM moves to ACTIVE and link_up=1 on the same edge. With a clean comma stream, link_up rises on the edge that samples the 4th comma.
- ACTIVE grant rule (combinational from owner, burst_cnt and both valids):
  - Grant the non-owner if it is valid AND (the owner is not valid OR burst_cnt==BURST_MAX).
  - Otherwise grant the owner if it is valid.
  - Otherwise no grant.
  - reqN_ready = (state==ACTIVE) & grantN. At most one ready is high per cycle.
- ACTIVE transfer (ready & valid), output one cycle after acceptance:
  - phy_tx_data <= granted data, phy_tx_valid <= 1.
  - Same owner: burst_cnt <= min(burst_cnt+1, BURST_MAX).
  - New owner: owner <= grantee, burst_cnt <= 1.
- ACTIVE with no transfer: phy_tx_data <= IDLE_WORD, phy_tx_valid <= 0. owner and burst_cnt are unchanged.
- A lone requester streams every cycle indefinitely; the burst limit applies only while the other requester is valid.
- Link loss (ACTIVE only):
  - loss_cnt increments on each cycle with phy_rx_valid==0 and phy_rx_data[7:0]!=COMMA.
  - loss_cnt clears on phy_rx_valid==1 or on a comma cycle.
  - When it reaches LOSS_CNT: FSM -> TRAIN, link_up=0, align_cnt=0, loss_cnt=0.
  - Readys drop in the TRAIN cycle that follows. The word accepted on the loss edge is still output. owner and burst_cnt are kept.
- Reset asserted mid-burst: all outputs return immediately to their reset values. The in-flight word is discarded with no replay.

Decomposition:
- Shared package phy_pkg: IDLE_WORD, COMMA, FSM state localparams (IDLE/TRAIN/ACTIVE), DATA_W.
- One natural sub-module: phy_rr_arbiter. It contains owner, burst_cnt, the grant logic and the ready outputs.
- The FSM, comma counters and output register stay in phy_link_scheduler.

Test Plan:
- Reset: hold reset=0 for 3 clk, then release → phy_tx_data==0x0000BCBC, tx_valid=0, link_up=0, state IDLE then TRAIN; readys 0 throughout.
- Training glitch: rx commas x3, one 0x00000000 word, then commas x4 → link_up stays 0 after the first 3; rises on the 4th comma of the second run; no early transition.
- Single requester: req0 sends 0xFFFFFFFF, 0xF4FFEF7F, 0xE8EEE4EE back-to-back in ACTIVE → phy_tx_data shows each one cycle after acceptance with tx_valid=1; then 0x0000BCBC/valid 0 once req0_valid drops.
- Contention: both valid continuously with req0 owner → 4 req0 words, 4 req1 words, alternating in blocks of 4; never two readys high together.
- Link loss: in ACTIVE, drive rx_valid=0, rx_data=0x12345678 for 8 cycles → link_up=0, state TRAIN, readys 0 next cycle; 4 commas then restore ACTIVE.
- Reset mid-burst: assert reset during the req1 block → outputs return to IDLE_WORD/0 asynchronously; after release and retraining, req0 is granted first.
